// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: control-bundle bit positions, RV32I opcodes
// (instr[6:2]), ALUOp encodings and operand-usage helpers.
package id_ex_stage_pkg;

  localparam int CTRL_W              = 12;
  localparam int CTRL_BRANCH         = 11;
  localparam int CTRL_JUMP           = 10;
  localparam int CTRL_MEMREAD        = 9;
  localparam int CTRL_MEMTOREG       = 8;
  localparam int CTRL_ALUOP_HI       = 7;
  localparam int CTRL_ALUOP_LO       = 6;
  localparam int CTRL_MEMWRITE       = 5;
  localparam int CTRL_ALUSRC1        = 4;
  localparam int CTRL_ALUSRC2        = 3;
  localparam int CTRL_REGWRITE       = 2;
  localparam int CTRL_REGWRITESEL_HI = 1;
  localparam int CTRL_REGWRITESEL_LO = 0;

  localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
  localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
  localparam logic [4:0] OPCODE_STORE   = 5'b01000;
  localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
  localparam logic [4:0] OPCODE_LUI     = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
  localparam logic [4:0] OPCODE_JALR    = 5'b11001;
  localparam logic [4:0] OPCODE_JAL     = 5'b11011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  function automatic logic op_uses_rs1(input logic [4:0] opcode);
    return !(opcode == OPCODE_LUI || opcode == OPCODE_AUIPC || opcode == OPCODE_JAL);
  endfunction

  function automatic logic op_uses_rs2(input logic [4:0] opcode);
    return (opcode == OPCODE_BRANCH || opcode == OPCODE_STORE || opcode == OPCODE_ARITH_R);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: purely combinational compare of the ID instruction's
// source registers against a load currently sitting in EX.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       lu_hazard
);

  logic uses_rs1;
  logic uses_rs2;
  logic rs1_match;
  logic rs2_match;

  // The rs fields of U/J-type encodings hold immediate bits, so they must not match.
  assign uses_rs1  = op_uses_rs1(id_opcode);
  assign uses_rs2  = op_uses_rs2(id_opcode);
  assign rs1_match = uses_rs1 && (ex_rd == id_rs1);
  assign rs2_match = uses_rs2 && (ex_rd == id_rs2);

  assign lu_hazard = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0)
                     && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: 1-cycle latency; freezes on ex_hold, bubbles on flush,
// load-use hazard or empty ID, and stalls IF/ID combinationally.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic              ex_hold,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7_5,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ex_valid_q,    ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
  logic [4:0]        ex_rs1_q,      ex_rs1_d;
  logic [4:0]        ex_rs2_q,      ex_rs2_d;
  logic [4:0]        ex_rd_q,       ex_rd_d;
  logic [2:0]        ex_funct3_q,   ex_funct3_d;
  logic              ex_funct7_5_q, ex_funct7_5_d;
  logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
  logic              lu_hazard;

  id_ex_stage_hazard_detect u_hazard_detect (
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_valid   (ex_valid_q),
    .ex_memread (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rd      (ex_rd_q),
    .lu_hazard  (lu_hazard)
  );

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7_5_d = ex_funct7_5_q;
    stall_cnt_d   = stall_cnt_q;
    if (!ex_hold) begin
      if (ex_flush || lu_hazard || !id_valid) begin
        // Bubble zeroes every field so no RegWrite/MemWrite/Branch reaches EX.
        ex_valid_d    = 1'b0;
        ex_ctrl_d     = '0;
        ex_pc_d       = '0;
        ex_rs1_data_d = '0;
        ex_rs2_data_d = '0;
        ex_imm_d      = '0;
        ex_rs1_d      = '0;
        ex_rs2_d      = '0;
        ex_rd_d       = '0;
        ex_funct3_d   = '0;
        ex_funct7_5_d = 1'b0;
        if (!ex_flush && lu_hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end else begin
        ex_valid_d    = 1'b1;
        ex_ctrl_d     = id_ctrl;
        ex_pc_d       = id_pc;
        ex_rs1_data_d = id_rs1_data;
        ex_rs2_data_d = id_rs2_data;
        ex_imm_d      = id_imm;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        ex_rd_d       = id_rd;
        ex_funct3_d   = id_funct3;
        ex_funct7_5_d = id_funct7_5;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_funct7_5_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7_5_q <= ex_funct7_5_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // A flush redirects fetch anyway, so a hazard against the squashed ID instruction must not stall.
  assign stall_if_id = !rst && (ex_hold || (lu_hazard && !ex_flush));

  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_funct7_5 = ex_funct7_5_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued as each ID word
// is driven and compared after the next rising edge.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [4:0] OP_LD  = 5'b00000, OP_ARI = 5'b00100, OP_AUI = 5'b00101;
  localparam logic [4:0] OP_ST  = 5'b01000, OP_ARR = 5'b01100, OP_LUI = 5'b01101;
  localparam logic [4:0] OP_BR  = 5'b11000, OP_JLR = 5'b11001, OP_JAL = 5'b11011;

  localparam logic [11:0] C_ADD  = 12'h01D;
  localparam logic [11:0] C_LW   = 12'h30C;
  localparam logic [11:0] C_ADDI = 12'h0CD;
  localparam logic [11:0] C_LUI  = 12'h01E;

  typedef struct packed {
    logic        valid;
    logic [11:0] ctrl;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } ex_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic [11:0] ctrl;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic        hold, flush;
  } in_t;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_funct7_5, ex_hold, ex_flush;
  logic [4:0] id_opcode, id_rs1, id_rs2, id_rd;
  logic [11:0] id_ctrl;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [2:0] id_funct3;
  logic ex_valid, ex_funct7_5, stall_if_id;
  logic [11:0] ex_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [CNT_W-1:0] stall_cnt;

  ex_t dut_ex;
  assign dut_ex = {ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5};

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_5(id_funct7_5), .ex_hold(ex_hold), .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
    .stall_if_id(stall_if_id), .stall_cnt(stall_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  ex_t sb_q[$];
  ex_t mdl;
  logic [CNT_W-1:0] mdl_cnt;
  logic obs_stall;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic in_t mk(input logic [4:0] op, input logic [11:0] ctrl,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    in_t r;
    r.valid = 1'b1; r.op = op; r.ctrl = ctrl;
    r.pc = $urandom; r.rs1d = $urandom; r.rs2d = $urandom; r.imm = $urandom;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.f3 = 3'($urandom); r.f7 = 1'($urandom);
    r.hold = 1'b0; r.flush = 1'b0;
    return r;
  endfunction

  task automatic drive(input in_t in);
    id_valid = in.valid; id_opcode = in.op; id_ctrl = in.ctrl; id_pc = in.pc;
    id_rs1_data = in.rs1d; id_rs2_data = in.rs2d; id_imm = in.imm;
    id_rs1 = in.rs1; id_rs2 = in.rs2; id_rd = in.rd; id_funct3 = in.f3;
    id_funct7_5 = in.f7; ex_hold = in.hold; ex_flush = in.flush;
  endtask

  // One clock: check combinational stall, queue expected EX contents, compare after the edge.
  task automatic cyc(input in_t in);
    logic u1, u2, hz, exp_stall;
    ex_t nxt;
    ex_t got;
    drive(in);
    #1;
    u1 = !(in.op == OP_LUI || in.op == OP_AUI || in.op == OP_JAL);
    u2 = (in.op == OP_BR || in.op == OP_ST || in.op == OP_ARR);
    hz = in.valid && mdl.valid && mdl.ctrl[9] && (mdl.rd != 5'd0) &&
         ((u1 && mdl.rd == in.rs1) || (u2 && mdl.rd == in.rs2));
    exp_stall = in.hold || (hz && !in.flush);
    obs_stall = stall_if_id;
    chk("stall_if_id", 160'(stall_if_id), 160'(exp_stall));
    if (in.hold) nxt = mdl;
    else if (in.flush || hz || !in.valid) begin
      nxt = '0;
      if (!in.flush && hz && mdl_cnt != {CNT_W{1'b1}}) mdl_cnt = mdl_cnt + 1'b1;
    end else
      nxt = '{1'b1, in.ctrl, in.pc, in.rs1d, in.rs2d, in.imm, in.rs1, in.rs2, in.rd, in.f3, in.f7};
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    mdl = nxt;
    got = sb_q.pop_front();
    chk("ex_regs", dut_ex, got);
    chk("stall_cnt", 160'(stall_cnt), 160'(mdl_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_t in, lw5, use5;
    ex_t frozen;
    logic [4:0] ops [9] = '{OP_LD, OP_ARI, OP_AUI, OP_ST, OP_ARR, OP_LUI, OP_BR, OP_JLR, OP_JAL};

    // Reset with random inputs, including hold/flush.
    rst = 1'b1;
    in = mk(5'($urandom), 12'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    in.hold = 1'b1; in.flush = 1'b1;
    drive(in);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex", dut_ex, '0);
    chk("rst_cnt", 160'(stall_cnt), '0);
    chk("rst_stall", 160'(stall_if_id), '0);
    rst = 1'b0;
    mdl = '0; mdl_cnt = '0;

    // Normal issue: add x3,x1,x2.
    cyc(mk(OP_ARR, C_ADD, 5'd3, 5'd1, 5'd2));
    chk("add_valid", 160'(ex_valid), 160'(1'b1));
    chk("add_ctrl", 160'(ex_ctrl), 160'(12'h01D));
    chk("add_rd", 160'(ex_rd), 160'(5'd3));

    // Load-use: lw x5,0(x1); add x6,x5,x7 -> one bubble then the add.
    cyc(mk(OP_LD, C_LW, 5'd5, 5'd1, 5'd0));
    use5 = mk(OP_ARR, C_ADD, 5'd6, 5'd5, 5'd7);
    cyc(use5);
    chk("lu_stall", 160'(obs_stall), 160'(1'b1));
    chk("lu_bubble", 160'(ex_ctrl), '0);
    cyc(use5);
    chk("lu_nostall2", 160'(obs_stall), '0);
    chk("lu_issue", 160'(ex_ctrl), 160'(12'h01D));
    chk("lu_cnt", 160'(stall_cnt), 160'(6'd1));

    // No false stalls.
    cyc(mk(OP_LD, C_LW, 5'd0, 5'd1, 5'd0));
    cyc(mk(OP_ARR, C_ADD, 5'd6, 5'd0, 5'd0));
    chk("x0_nostall", 160'(obs_stall), '0);
    cyc(mk(OP_LD, C_LW, 5'd5, 5'd1, 5'd0));
    cyc(mk(OP_LUI, C_LUI, 5'd5, 5'd5, 5'd5));
    chk("lui_nostall", 160'(obs_stall), '0);
    cyc(mk(OP_LD, C_LW, 5'd5, 5'd1, 5'd0));
    cyc(mk(OP_ARI, C_ADDI, 5'd6, 5'd7, 5'd5));
    chk("addi_nostall", 160'(obs_stall), '0);

    // Flush beats hazard.
    lw5 = mk(OP_LD, C_LW, 5'd5, 5'd1, 5'd0);
    cyc(lw5);
    in = use5; in.flush = 1'b1;
    cyc(in);
    chk("flush_nostall", 160'(obs_stall), '0);
    chk("flush_bubble", 160'(ex_valid), '0);
    chk("flush_cnt", 160'(stall_cnt), 160'(6'd1));

    // Hold for 3 cycles with changing ID and a flush in the middle, then release into a hazard.
    cyc(lw5);
    frozen = mdl;
    for (int i = 0; i < 3; i++) begin
      in = mk(OP_ARR, C_ADD, 5'(i + 8), 5'd5, 5'd9);
      in.hold = 1'b1; in.flush = (i == 1);
      cyc(in);
      chk("hold_stall", 160'(obs_stall), 160'(1'b1));
      chk("hold_frozen", dut_ex, frozen);
    end
    chk("hold_cnt", 160'(stall_cnt), 160'(6'd1));
    cyc(use5);
    chk("release_stall", 160'(obs_stall), 160'(1'b1));
    chk("release_cnt", 160'(stall_cnt), 160'(6'd2));
    cyc(use5);

    // Random traffic over a small register set to provoke frequent hazards.
    for (int i = 0; i < 300; i++) begin
      in = mk(ops[$urandom_range(0, 8)], 12'($urandom), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      in.valid = ($urandom_range(0, 99) < 85);
      in.hold  = ($urandom_range(0, 99) < 15);
      in.flush = ($urandom_range(0, 99) < 10);
      cyc(in);
    end

    // Saturation: self-dependent loads every other cycle until the counter tops out.
    in = mk(OP_LD, C_LW, 5'd5, 5'd5, 5'd0);
    for (int i = 0; i < 300 && mdl_cnt != {CNT_W{1'b1}}; i++) cyc(in);
    for (int i = 0; i < 6; i++) cyc(in);
    chk("sat_cnt", 160'(stall_cnt), 160'(6'h3F));

    // Reset mid-operation wins over hold and flush.
    cyc(mk(OP_ARR, C_ADD, 5'd7, 5'd1, 5'd2));
    in = mk(OP_ARR, C_ADD, 5'd8, 5'd1, 5'd2);
    in.hold = 1'b1; in.flush = 1'b1;
    drive(in);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 160'(stall_if_id), '0);
    @(posedge clk);
    #1;
    chk("midrst_ex", dut_ex, '0);
    chk("midrst_cnt", 160'(stall_cnt), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
